la_dpram_ctrl: RTL
==================

LA_DPRAM_CTRL -- requirements
Module: la_dpram_ctrl

Interface
REQ-001 Parameter DW, default 32, data width; matches attached la_dpram DW.
REQ-002 Parameter AW, default 10, address width; depth = 2^AW.
REQ-003 Parameter INIT, default 1: 1 clears memory after reset, 0 skips the clear.
REQ-004 clk  in  1  single clock; drives RAM wr_clk and rd_clk.
REQ-005 nreset  in  1  reset, asynchronous, active-low.
REQ-006 a_req, a_gnt  in/out  1/1  write requester A handshake; a_addr in AW, a_din in DW, a_wmask in DW.
REQ-007 b_req, b_gnt  in/out  1/1  write requester B handshake; b_addr in AW, b_din in DW, b_wmask in DW.
REQ-008 rd_req, rd_gnt  in/out  1/1  read request handshake; rd_addr in AW.
REQ-009 rd_valid  out  1  read data valid; rd_dout  out  DW  read data.
REQ-010 init_done  out  1  memory clear complete, ports open.
REQ-011 ram_wr_ce, ram_wr_we  out  1/1; ram_wr_addr out AW; ram_wr_din out DW; ram_wr_wmask out DW -- RAM write port.
REQ-012 ram_rd_ce  out  1; ram_rd_addr out AW; ram_rd_dout in DW -- RAM read port; RAM read latency is 1 cycle.

Function
REQ-013 States: INIT (clear) and RUN; reset enters INIT if INIT=1, RUN if INIT=0.
REQ-014 INIT: AW-bit counter starts at 0; each cycle drives ram_wr_ce=1, ram_wr_we=1, ram_wr_wmask all-ones, ram_wr_din=0, ram_wr_addr=counter; counter increments by 1.
REQ-015 INIT -> RUN in the cycle after address 2^AW-1 is written; a clear takes exactly 2^AW cycles.
REQ-016 init_done=1 in RUN only; in INIT a_gnt=b_gnt=rd_gnt=0 and all requests are held off (not dropped; requesters keep req high).
REQ-017 RUN write arbitration is combinational: only a_req -> a_gnt; only b_req -> b_gnt; both -> round-robin grant.
REQ-018 Round-robin pointer: one flop holding the last granted requester, reset value B, so A wins the first contention.
REQ-019 Pointer updates only on a cycle with a grant; uncontended grants also update it.
REQ-020 At most one of a_gnt/b_gnt is high in any cycle; a grant is never asserted without its req.
REQ-021 A granted cycle drives ram_wr_ce=1, ram_wr_we=1 and the winner's addr/din/wmask the same cycle; a transfer completes on req&gnt.
REQ-022 No grant: ram_wr_ce=0, ram_wr_we=0, ram_wr_addr/din/wmask=0.
REQ-023 RUN: rd_gnt=rd_req; ram_rd_ce=rd_req&rd_gnt; ram_rd_addr=rd_addr.
REQ-024 rd_valid is a flop set to ram_rd_ce, so it asserts exactly one cycle after the granted read; rd_dout=ram_rd_dout unmodified.
REQ-025 Back-to-back reads sustain 1 read/cycle; back-to-back writes sustain 1 write/cycle; reads and writes proceed concurrently.
REQ-026 Same-address read and write in one cycle: no forwarding; rd_dout is whatever the RAM returns (pre-write data for la_dpram).
REQ-027 ram_wr_addr is AW bits, so counter wrap-around past 2^AW-1 is impossible; INIT terminates on the terminal count, never on the wrap.

Reset
REQ-028 nreset low asynchronously forces: counter=0, pointer=B, rd_valid=0, init_done=0, state=INIT (INIT=1) or RUN (INIT=0).
REQ-029 While nreset is low, all grants and ram_*_ce are 0.
REQ-030 Reset mid-INIT or mid-RUN aborts the operation; a new clear restarts from address 0; an in-flight read produces no rd_valid.

Verification
REQ-031 Clear: DW=8, AW=4, INIT=1, release reset -> 16 consecutive writes of 0x00 to addr 0..15 with init_done=0; init_done=1 on cycle 17; all reads return 0x00.
REQ-032 Contention: a_req=b_req=1 held for 4 cycles in RUN -> grants A,B,A,B; exactly one grant per cycle.
REQ-033 Solo then contend: b_req alone 1 cycle (grant B), then both -> A granted first.
REQ-034 Read latency: write 0x5A to addr 3, next cycle read addr 3 -> rd_valid=1 with rd_dout=0x5A exactly one cycle after rd_gnt.
REQ-035 Held off: a_req=1 during INIT -> a_gnt=0 until the first RUN cycle, then a_gnt=1 and that write lands.
REQ-036 Mid-clear reset: assert nreset low at counter=7 -> all outputs at reset values; after release the clear restarts at addr 0 and takes 16 cycles.

Source files
------------

// File: rtl/la_dpram_ctrl_if.sv
// Requester-side bus of la_dpram_ctrl: write ports A and B, one read port
// and the clear-complete status flag.
interface la_dpram_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 10
);

   logic          a_req;
   logic          a_gnt;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_din;
   logic [DW-1:0] a_wmask;

   logic          b_req;
   logic          b_gnt;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_din;
   logic [DW-1:0] b_wmask;

   logic          rd_req;
   logic          rd_gnt;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [DW-1:0] rd_dout;

   logic          init_done;

   modport master (
      output a_req, a_addr, a_din, a_wmask,
      output b_req, b_addr, b_din, b_wmask,
      output rd_req, rd_addr,
      input  a_gnt, b_gnt, rd_gnt, rd_valid, rd_dout, init_done
   );

   modport slave (
      input  a_req, a_addr, a_din, a_wmask,
      input  b_req, b_addr, b_din, b_wmask,
      input  rd_req, rd_addr,
      output a_gnt, b_gnt, rd_gnt, rd_valid, rd_dout, init_done
   );

endinterface

// File: rtl/la_dpram_ctrl.sv
// Front-end for a 1-cycle-latency dual-port RAM: optional post-reset clear,
// round-robin arbitration of two write requesters, and a pass-through read port.
module la_dpram_ctrl #(
   parameter int DW   = 32,
   parameter int AW   = 10,
   parameter int INIT = 1
) (
   input  logic             clk,
   input  logic             nreset,
   la_dpram_ctrl_if.slave   bus,
   // RAM write port
   output logic             ram_wr_ce,
   output logic             ram_wr_we,
   output logic [AW-1:0]    ram_wr_addr,
   output logic [DW-1:0]    ram_wr_din,
   output logic [DW-1:0]    ram_wr_wmask,
   // RAM read port
   output logic             ram_rd_ce,
   output logic [AW-1:0]    ram_rd_addr,
   input  logic [DW-1:0]    ram_rd_dout
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   // Identity of the requester granted most recently.
   typedef enum logic {
      RR_A,
      RR_B
   } rr_t;

   localparam state_t RESET_STATE = (INIT != 0) ? ST_INIT : ST_RUN;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_nxt;
   rr_t           rr_last;
   logic          rd_valid_q;
   logic          run;
   logic          a_gnt;
   logic          b_gnt;

   // Ports are open only in RUN and never while reset is asserted, which also
   // keeps grants low when INIT=0 resets straight into RUN.
   assign run = nreset && (state == ST_RUN);

   // ------------------------------------------------------------------
   // Write arbitration: uncontended requests win outright; on contention
   // the requester that was not granted last goes next.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no
      // path leaves it unassigned, which would infer a latch.
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (run) begin
         if (bus.a_req && bus.b_req) begin
            a_gnt = (rr_last == RR_B);
            b_gnt = (rr_last == RR_A);
         end else begin
            a_gnt = bus.a_req;
            b_gnt = bus.b_req;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state and RAM write port
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      ram_wr_ce    = 1'b0;
      ram_wr_we    = 1'b0;
      ram_wr_addr  = '0;
      ram_wr_din   = '0;
      ram_wr_wmask = '0;

      unique case (state)
         ST_INIT: begin
            if (nreset) begin
               ram_wr_ce    = 1'b1;
               ram_wr_we    = 1'b1;
               ram_wr_addr  = cnt;
               ram_wr_wmask = '1;
               cnt_nxt      = cnt + AW'(1);
               // Leave on the terminal count; the increment wraps cnt back
               // to 0, ready for the next clear.
               if (cnt == '1) begin
                  state_nxt = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (a_gnt) begin
               ram_wr_ce    = 1'b1;
               ram_wr_we    = 1'b1;
               ram_wr_addr  = bus.a_addr;
               ram_wr_din   = bus.a_din;
               ram_wr_wmask = bus.a_wmask;
            end else if (b_gnt) begin
               ram_wr_ce    = 1'b1;
               ram_wr_we    = 1'b1;
               ram_wr_addr  = bus.b_addr;
               ram_wr_din   = bus.b_din;
               ram_wr_wmask = bus.b_wmask;
            end
         end

         default: begin
            state_nxt = RESET_STATE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state      <= RESET_STATE;
         cnt        <= '0;
         rr_last    <= RR_B;
         rd_valid_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         rd_valid_q <= ram_rd_ce;
         if (a_gnt || b_gnt) begin
            rr_last <= b_gnt ? RR_B : RR_A;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read port: granted whenever open; data is forwarded untouched, so a
   // same-cycle write to the read address is not visible until later.
   // ------------------------------------------------------------------
   assign bus.rd_gnt    = run && bus.rd_req;
   assign ram_rd_ce     = bus.rd_req && bus.rd_gnt;
   assign ram_rd_addr   = bus.rd_addr;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_dout   = ram_rd_dout;

   assign bus.a_gnt     = a_gnt;
   assign bus.b_gnt     = b_gnt;
   assign bus.init_done = run;

endmodule
